// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU definitions for the integer-register writeback path
package fpu_pkg;
    localparam int NUM_INT_WB_SRC = 3;
    typedef enum logic [1:0] {
        SRC_CLASSIFY = 2'd0,
        SRC_COMPARE  = 2'd1,
        SRC_CVT      = 2'd2
    } int_wb_src_e;
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
    } int_wb_t;
endpackage

// File: rtl/fp_int_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first requester at or after the pointer wins
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);
    assign o_any = |i_req;
    always_comb begin : p_sel
        int j;
        j = 0;
        o_gnt = '0;
        o_idx = '0;
        // walk offsets farthest-first so the nearest requester is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N;
            if (i_req[W'(j)]) begin
                o_gnt = '0;
                o_gnt[W'(j)] = 1'b1;
                o_idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/fp_int_wb_arbiter.sv
// fp_int_wb_arbiter: per-source holding registers merged onto one integer writeback port
module fp_int_wb_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_SRC = NUM_INT_WB_SRC,
    parameter int RD_W = 5,
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic [NUM_SRC-1:0]      i_src_valid,
    input  logic [NUM_SRC*32-1:0]   i_src_result,
    input  logic [NUM_SRC*RD_W-1:0] i_src_rd,
    output logic [NUM_SRC-1:0]      o_src_full,
    output logic                    o_wb_valid,
    output logic [31:0]             o_wb_result,
    output logic [RD_W-1:0]         o_wb_rd,
    output logic [SW-1:0]           o_wb_src,
    input  logic                    i_wb_ready,
    output logic                    o_overflow
);
    logic [NUM_SRC-1:0] r_hold_valid;
    logic [31:0]        r_hold_result [NUM_SRC];
    logic [RD_W-1:0]    r_hold_rd     [NUM_SRC];
    logic [SW-1:0]      r_ptr;
    logic [SW-1:0]      r_lock_idx;
    logic               r_lock;
    logic               r_overflow;
    logic [NUM_SRC-1:0] w_rr_gnt;
    logic [SW-1:0]      w_rr_idx;
    logic               w_rr_any;
    logic [SW-1:0]      w_sel;
    logic [NUM_SRC-1:0] w_sel_oh;
    logic               w_handshake;

    rr_arbiter #(.N(NUM_SRC), .W(SW)) u_rr (
        .i_req (r_hold_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // a stalled grant stays pinned to its source so the data cannot change under the regfile
    assign w_sel       = r_lock ? r_lock_idx : w_rr_idx;
    assign w_sel_oh    = r_lock ? NUM_SRC'(1) << r_lock_idx : w_rr_gnt;
    assign w_handshake = o_wb_valid && i_wb_ready;
    assign o_src_full  = r_hold_valid;
    assign o_overflow  = r_overflow;
    assign o_wb_valid  = w_rr_any && !i_flush;
    assign o_wb_result = o_wb_valid ? r_hold_result[w_sel] : '0;
    assign o_wb_rd     = o_wb_valid ? r_hold_rd[w_sel] : '0;
    assign o_wb_src    = o_wb_valid ? w_sel : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_valid <= '0;
            r_ptr        <= '0;
            r_lock       <= 1'b0;
            r_lock_idx   <= '0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_hold_result[i] <= '0;
                r_hold_rd[i]     <= '0;
            end
        end else if (i_flush) begin
            r_hold_valid <= '0;
            r_ptr        <= '0;
            r_lock       <= 1'b0;
        end else begin
            // capture only into an empty slot; a slot draining this cycle still rejects input
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i_src_valid[i] && !r_hold_valid[i]) begin
                    r_hold_valid[i]  <= 1'b1;
                    r_hold_result[i] <= i_src_result[i*32 +: 32];
                    r_hold_rd[i]     <= i_src_rd[i*RD_W +: RD_W];
                end else if (w_handshake && w_sel_oh[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
            if (|(i_src_valid & r_hold_valid))
                r_overflow <= 1'b1;
            if (w_handshake) begin
                r_ptr  <= (int'(w_sel) == NUM_SRC - 1) ? '0 : w_sel + 1'b1;
                r_lock <= 1'b0;
            end else if (o_wb_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end
        end
    end
endmodule

// File: tb/tb_fp_int_wb_arbiter.sv
// tb_fp_int_wb_arbiter: directed scenarios plus random traffic against a behavioural slot model
module tb_fp_int_wb_arbiter;
    logic        clk;
    logic        i_rst;
    logic        i_flush;
    logic [2:0]  i_src_valid;
    logic [95:0] i_src_result;
    logic [14:0] i_src_rd;
    logic [2:0]  o_src_full;
    logic        o_wb_valid;
    logic [31:0] o_wb_result;
    logic [4:0]  o_wb_rd;
    logic [1:0]  o_wb_src;
    logic        i_wb_ready;
    logic        o_overflow;

    int checks = 0;
    int failures = 0;

    logic        m_v   [3];
    logic [31:0] m_res [3];
    logic [4:0]  m_rd  [3];
    int          m_ptr;
    int          m_lidx;
    logic        m_lock;
    logic        m_ovf;

    logic        obs_valid;
    logic [31:0] obs_res;
    logic [4:0]  obs_rd;
    logic [1:0]  obs_src;
    logic [2:0]  obs_full;
    logic        obs_ovf;

    fp_int_wb_arbiter #(.NUM_SRC(3), .RD_W(5)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_src_valid  (i_src_valid),
        .i_src_result (i_src_result),
        .i_src_rd     (i_src_rd),
        .o_src_full   (o_src_full),
        .o_wb_valid   (o_wb_valid),
        .o_wb_result  (o_wb_result),
        .o_wb_rd      (o_wb_rd),
        .o_wb_src     (o_wb_src),
        .i_wb_ready   (i_wb_ready),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_res[i] = '0;
            m_rd[i] = '0;
        end
        m_ptr = 0;
        m_lidx = 0;
        m_lock = 1'b0;
        m_ovf = 1'b0;
    endtask

    // one clock: drive, compare every output against the model, then advance the model past the edge
    task automatic cycle(input logic [2:0] v, input logic [95:0] res, input logic [14:0] rd,
                         input logic rdy, input logic fl, input logic rs);
        int sel;
        logic ev;
        logic [2:0] full;
        @(negedge clk);
        i_rst = rs;
        i_flush = fl;
        i_src_valid = v;
        i_src_result = res;
        i_src_rd = rd;
        i_wb_ready = rdy;
        #1;
        sel = -1;
        if (m_lock) sel = m_lidx;
        else
            for (int off = 0; off < 3; off++)
                if (sel < 0 && m_v[(m_ptr + off) % 3]) sel = (m_ptr + off) % 3;
        ev = (sel >= 0) && !fl;
        full = {m_v[2], m_v[1], m_v[0]};
        obs_valid = o_wb_valid;
        obs_res = o_wb_result;
        obs_rd = o_wb_rd;
        obs_src = o_wb_src;
        obs_full = o_src_full;
        obs_ovf = o_overflow;
        chk("full", 32'(o_src_full), 32'(full));
        chk("wb_valid", 32'(o_wb_valid), 32'(ev));
        chk("wb_result", o_wb_result, ev ? m_res[sel] : 32'h0);
        chk("wb_rd", 32'(o_wb_rd), ev ? 32'(m_rd[sel]) : 32'h0);
        chk("wb_src", 32'(o_wb_src), ev ? 32'(sel) : 32'h0);
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        if (rs) model_reset();
        else if (fl) begin
            for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
            m_ptr = 0;
            m_lock = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (v[i]) begin
                    if (m_v[i]) m_ovf = 1'b1;
                    else begin
                        m_v[i] = 1'b1;
                        m_res[i] = res[i*32 +: 32];
                        m_rd[i] = rd[i*5 +: 5];
                    end
                end
            if (ev && rdy) begin
                m_v[sel] = 1'b0;
                m_ptr = (sel + 1) % 3;
                m_lock = 1'b0;
            end else if (ev) begin
                m_lock = 1'b1;
                m_lidx = sel;
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_flush = 1'b0;
        i_src_valid = '0;
        i_src_result = '0;
        i_src_rd = '0;
        i_wb_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(obs_valid), 32'h0);
        chk("rst_full", 32'(obs_full), 32'h0);
        chk("rst_ovf", 32'(obs_ovf), 32'h0);

        // single result, one-cycle latency
        cycle(3'b001, {64'h0, 32'h40}, {10'h0, 5'd7}, 1'b1, 1'b0, 1'b0);
        chk("single_pre", 32'(obs_valid), 32'h0);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("single_valid", 32'(obs_valid), 32'h1);
        chk("single_res", obs_res, 32'h40);
        chk("single_rd", 32'(obs_rd), 32'd7);
        chk("single_src", 32'(obs_src), 32'd0);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("single_drained", 32'(obs_full), 32'h0);

        // simultaneous arrivals from ptr 0
        cycle(3'b000, '0, '0, 1'b1, 1'b1, 1'b0);
        cycle(3'b111, {32'h33, 32'h22, 32'h11}, {5'd3, 5'd2, 5'd1}, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
            chk("simul_src", 32'(obs_src), 32'(k));
            chk("simul_valid", 32'(obs_valid), 32'h1);
        end
        cycle(3'b011, {32'h0, 32'h55, 32'h44}, {5'd0, 5'd9, 5'd8}, 1'b1, 1'b0, 1'b0);
        chk("simul_empty", 32'(obs_valid), 32'h0);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("simul_ptr0", 32'(obs_src), 32'd0);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);

        // backpressure locks the grant on src1 even after src0 arrives
        cycle(3'b000, '0, '0, 1'b1, 1'b1, 1'b0);
        cycle(3'b010, {32'h0, 32'hABCD, 32'h0}, {5'd0, 5'd3, 5'd0}, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_src_c1", 32'(obs_src), 32'd1);
        cycle(3'b001, {64'h0, 32'h77}, {10'h0, 5'd4}, 1'b0, 1'b0, 1'b0);
        chk("bp_src_c2", 32'(obs_src), 32'd1);
        for (int k = 0; k < 2; k++) begin
            cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
            chk("bp_src_hold", 32'(obs_src), 32'd1);
            chk("bp_rd_hold", 32'(obs_rd), 32'd3);
        end
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_release_src", 32'(obs_src), 32'd1);
        chk("bp_release_res", obs_res, 32'hABCD);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_next_src", 32'(obs_src), 32'd0);
        chk("bp_next_res", obs_res, 32'h77);

        // overflow is sticky across flush
        cycle(3'b000, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle(3'b100, {32'h1, 64'h0}, {5'd1, 10'h0}, 1'b0, 1'b0, 1'b0);
        cycle(3'b100, {32'h2, 64'h0}, {5'd2, 10'h0}, 1'b0, 1'b0, 1'b0);
        chk("ovf_before", 32'(obs_ovf), 32'h0);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(obs_ovf), 32'h1);
        chk("ovf_kept_res", obs_res, 32'h1);
        cycle(3'b000, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("ovf_after_flush", 32'(obs_ovf), 32'h1);
        chk("ovf_flush_full", 32'(obs_full), 32'h0);

        // flush with all three full and ready high
        cycle(3'b111, {32'h9, 32'h8, 32'h7}, {5'd9, 5'd8, 5'd7}, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 32'(obs_valid), 32'h0);
        chk("flush_full_pre", 32'(obs_full), 32'h7);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_full_post", 32'(obs_full), 32'h0);
        cycle(3'b011, {32'h0, 32'h2, 32'h1}, {5'd0, 5'd2, 5'd1}, 1'b1, 1'b0, 1'b0);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_ptr0", 32'(obs_src), 32'd0);

        // reset during a locked grant
        cycle(3'b100, {32'h5, 64'h0}, {5'd5, 10'h0}, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("rst_lock_valid", 32'(obs_valid), 32'h0);
        chk("rst_lock_ovf", 32'(obs_ovf), 32'h0);

        for (int n = 0; n < 400; n++) begin
            cycle(3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                  {$urandom, $urandom, $urandom}, 15'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 99) == 0);
        end
        for (int n = 0; n < 4; n++) cycle(3'b000, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("final_drained", 32'(obs_full), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
